id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 109 ++++++++++
 tb/tb_id_ex_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush and hold.
// Optional feature: define IDEX_PERF_CNT_EN to add bubble/flush event counters.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ID_Valid,
  input  logic [31:0] ID_RegData1,
  input  logic [31:0] ID_RegData2,
  input  logic [31:0] ID_SignImm,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic [4:0]  ID_WBAddr,
  input  logic        ID_UsesRt,
  input  logic        ID_RegWrite,
  input  logic        ID_MemRead,
  input  logic        ID_MemWrite,
  input  logic        ID_ALUSrc,
  input  logic [3:0]  ID_ALUOp,
  input  logic        Flush,
  input  logic        Hold,
  output logic        IE_Valid,
  output logic [31:0] IE_RegData1,
  output logic [31:0] IE_RegData2,
  output logic [31:0] IE_SignImm,
  output logic [4:0]  IE_Rs,
  output logic [4:0]  IE_Rt,
  output logic [4:0]  IE_WBAddr,
  output logic        IE_UsesRt,
  output logic        IE_RegWrite,
  output logic        IE_MemRead,
  output logic        IE_MemWrite,
  output logic        IE_ALUSrc,
  output logic [3:0]  IE_ALUOp,
  output logic        Stall_IFID
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [31:0] Cnt_Bubble,
  output logic [31:0] Cnt_Flush
`endif
);

  logic load_use;
  logic bubble;
  logic load;

  // A load to $0 never produces a value worth waiting for, so it never stalls.
  assign load_use = IE_Valid && IE_MemRead && (IE_WBAddr != 5'd0) && ID_Valid &&
                    ((IE_WBAddr == ID_Rs) || (ID_UsesRt && (IE_WBAddr == ID_Rt)));

  assign Stall_IFID = (load_use || Hold) && !Flush;

  // Flush and the load-use bubble both kill the slot; Hold outranks the bubble.
  assign bubble = Flush || (!Hold && load_use);
  assign load   = !Flush && !Hold && !load_use;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      IE_Valid    <= 1'b0;
      IE_RegData1 <= '0;
      IE_RegData2 <= '0;
      IE_SignImm  <= '0;
      IE_Rs       <= '0;
      IE_Rt       <= '0;
      IE_WBAddr   <= '0;
      IE_UsesRt   <= 1'b0;
      IE_RegWrite <= 1'b0;
      IE_MemRead  <= 1'b0;
      IE_MemWrite <= 1'b0;
      IE_ALUSrc   <= 1'b0;
      IE_ALUOp    <= '0;
    end else if (bubble) begin
      // Data fields of a killed slot are don't-care; leaving them saves toggles.
      IE_Valid    <= 1'b0;
      IE_RegWrite <= 1'b0;
      IE_MemRead  <= 1'b0;
      IE_MemWrite <= 1'b0;
    end else if (load) begin
      IE_Valid    <= ID_Valid;
      IE_RegData1 <= ID_RegData1;
      IE_RegData2 <= ID_RegData2;
      IE_SignImm  <= ID_SignImm;
      IE_Rs       <= ID_Rs;
      IE_Rt       <= ID_Rt;
      IE_WBAddr   <= ID_WBAddr;
      IE_UsesRt   <= ID_UsesRt;
      IE_RegWrite <= ID_RegWrite && ID_Valid;
      IE_MemRead  <= ID_MemRead && ID_Valid;
      IE_MemWrite <= ID_MemWrite && ID_Valid;
      IE_ALUSrc   <= ID_ALUSrc;
      IE_ALUOp    <= ID_ALUOp;
    end
  end

`ifdef IDEX_PERF_CNT_EN
  // Counters wrap naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      Cnt_Bubble <= '0;
      Cnt_Flush  <= '0;
    end else begin
      if (!Flush && !Hold && load_use) Cnt_Bubble <= Cnt_Bubble + 32'd1;
      if (Flush)                       Cnt_Flush  <= Cnt_Flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios plus a
// randomized run compared every cycle against a behavioural slot model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ID_Valid, ID_UsesRt, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_ALUSrc;
  logic [31:0] ID_RegData1, ID_RegData2, ID_SignImm;
  logic [4:0]  ID_Rs, ID_Rt, ID_WBAddr;
  logic [3:0]  ID_ALUOp;
  logic        Flush, Hold;
  logic        IE_Valid, IE_UsesRt, IE_RegWrite, IE_MemRead, IE_MemWrite, IE_ALUSrc;
  logic [31:0] IE_RegData1, IE_RegData2, IE_SignImm;
  logic [4:0]  IE_Rs, IE_Rt, IE_WBAddr;
  logic [3:0]  IE_ALUOp;
  logic        Stall_IFID;
`ifdef IDEX_PERF_CNT_EN
  logic [31:0] Cnt_Bubble, Cnt_Flush;
`endif

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .ID_Valid(ID_Valid), .ID_RegData1(ID_RegData1), .ID_RegData2(ID_RegData2),
    .ID_SignImm(ID_SignImm), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_WBAddr(ID_WBAddr),
    .ID_UsesRt(ID_UsesRt), .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
    .ID_MemWrite(ID_MemWrite), .ID_ALUSrc(ID_ALUSrc), .ID_ALUOp(ID_ALUOp),
    .Flush(Flush), .Hold(Hold),
    .IE_Valid(IE_Valid), .IE_RegData1(IE_RegData1), .IE_RegData2(IE_RegData2),
    .IE_SignImm(IE_SignImm), .IE_Rs(IE_Rs), .IE_Rt(IE_Rt), .IE_WBAddr(IE_WBAddr),
    .IE_UsesRt(IE_UsesRt), .IE_RegWrite(IE_RegWrite), .IE_MemRead(IE_MemRead),
    .IE_MemWrite(IE_MemWrite), .IE_ALUSrc(IE_ALUSrc), .IE_ALUOp(IE_ALUOp),
    .Stall_IFID(Stall_IFID)
`ifdef IDEX_PERF_CNT_EN
    , .Cnt_Bubble(Cnt_Bubble), .Cnt_Flush(Cnt_Flush)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected content of the EX slot; dk = data fields are meaningful.
  typedef struct packed {
    bit        valid, regw, memr, memw, alusrc, uses_rt, dk;
    bit [4:0]  rs, rt, wb;
    bit [3:0]  aluop;
    bit [31:0] rd1, rd2, imm;
  } slot_t;

  slot_t       m;
  int unsigned m_cb = 0, m_cf = 0;

  function automatic bit model_lu();
    return m.valid && m.memr && (m.wb != 0) && ID_Valid &&
           ((m.wb == ID_Rs) || (ID_UsesRt && (m.wb == ID_Rt)));
  endfunction

  function automatic bit model_stall();
    return (model_lu() || Hold) && !Flush;
  endfunction

  // Reference: what the slot must hold after each edge, by priority of events.
  always @(posedge clk) begin
    if (rst) begin
      m = '0;
      m.dk = 1'b1;
      m_cb = 0;
      m_cf = 0;
    end else if (Flush) begin
      m.valid = 0; m.regw = 0; m.memr = 0; m.memw = 0; m.dk = 0;
      m_cf++;
    end else if (Hold) begin
      m = m;
    end else if (model_lu()) begin
      m.valid = 0; m.regw = 0; m.memr = 0; m.memw = 0; m.dk = 0;
      m_cb++;
    end else begin
      m.valid = ID_Valid;
      m.regw = ID_RegWrite && ID_Valid;
      m.memr = ID_MemRead && ID_Valid;
      m.memw = ID_MemWrite && ID_Valid;
      m.alusrc = ID_ALUSrc; m.uses_rt = ID_UsesRt; m.dk = 1'b1;
      m.rs = ID_Rs; m.rt = ID_Rt; m.wb = ID_WBAddr; m.aluop = ID_ALUOp;
      m.rd1 = ID_RegData1; m.rd2 = ID_RegData2; m.imm = ID_SignImm;
    end
  end

  // Single compare process, mid-cycle, when outputs and inputs are stable.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ie_valid", IE_Valid, m.valid);
      check("ie_regwrite", IE_RegWrite, m.regw);
      check("ie_memread", IE_MemRead, m.memr);
      check("ie_memwrite", IE_MemWrite, m.memw);
      check("stall_ifid", Stall_IFID, model_stall());
      if (m.dk) begin
        check("ie_rs", IE_Rs, m.rs);
        check("ie_rt", IE_Rt, m.rt);
        check("ie_wbaddr", IE_WBAddr, m.wb);
        check("ie_usesrt", IE_UsesRt, m.uses_rt);
        check("ie_alusrc", IE_ALUSrc, m.alusrc);
        check("ie_aluop", IE_ALUOp, m.aluop);
        check("ie_regdata1", IE_RegData1, m.rd1);
        check("ie_regdata2", IE_RegData2, m.rd2);
        check("ie_signimm", IE_SignImm, m.imm);
      end
`ifdef IDEX_PERF_CNT_EN
      check("cnt_bubble", Cnt_Bubble, m_cb);
      check("cnt_flush", Cnt_Flush, m_cf);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_id(input bit v, input bit [4:0] rs, input bit [4:0] rt,
                        input bit [4:0] wb, input bit ur, input bit mr, input bit rw);
    ID_Valid = v; ID_Rs = rs; ID_Rt = rt; ID_WBAddr = wb;
    ID_UsesRt = ur; ID_MemRead = mr; ID_RegWrite = rw;
    ID_MemWrite = 1'b0;
    ID_ALUSrc = 1'($urandom);
    ID_ALUOp = 4'($urandom);
    ID_RegData1 = $urandom; ID_RegData2 = $urandom; ID_SignImm = $urandom;
  endtask

  logic [31:0] held_imm;

  initial begin
    rst = 1'b1; Flush = 1'b0; Hold = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_valid", IE_Valid, 32'd0);
    check("reset_signimm", IE_SignImm, 32'd0);
    #1 check("reset_stall", Stall_IFID, 32'd0);

    // Load-use on Rs: one stall, one bubble, then the user loads.
    set_id(1, 5'd1, 5'd2, 5'd8, 0, 1, 1);
    tick();
    set_id(1, 5'd8, 5'd3, 5'd9, 0, 0, 1);
    #1 check("lu_rs_stall", Stall_IFID, 32'd1);
    tick();
    check("lu_rs_bubble", IE_Valid, 32'd0);
    #1 check("lu_rs_clear", Stall_IFID, 32'd0);
    tick();
    check("lu_rs_loaded_valid", IE_Valid, 32'd1);
    check("lu_rs_loaded_rs", IE_Rs, 32'd8);

    // Rt matches but is not a register operand: no hazard.
    set_id(1, 5'd1, 5'd2, 5'd8, 0, 1, 1);
    tick();
    set_id(1, 5'd3, 5'd8, 5'd9, 0, 0, 1);
    #1 check("rt_unused_stall", Stall_IFID, 32'd0);
    tick();
    check("rt_unused_valid", IE_Valid, 32'd1);
    check("rt_unused_rt", IE_Rt, 32'd8);

    // Flush beats Hold and load-use.
    set_id(1, 5'd1, 5'd2, 5'd8, 0, 1, 1);
    tick();
    set_id(1, 5'd8, 5'd8, 5'd9, 1, 0, 1);
    Flush = 1'b1; Hold = 1'b1;
    #1 check("flush_stall", Stall_IFID, 32'd0);
    tick();
    Flush = 1'b0; Hold = 1'b0;
    check("flush_valid", IE_Valid, 32'd0);
    check("flush_regwrite", IE_RegWrite, 32'd0);

    // Hold for three cycles while decode keeps changing.
    set_id(1, 5'd5, 5'd6, 5'd7, 1, 0, 1);
    held_imm = ID_SignImm;
    tick();
    Hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1);
      #1 check("hold_stall", Stall_IFID, 32'd1);
      tick();
      check("hold_rs", IE_Rs, 32'd5);
      check("hold_imm", IE_SignImm, held_imm);
    end
    Hold = 1'b0;

    // Load to $0 followed by a reader of $0: no bubble, RegWrite passes through.
    set_id(1, 5'd4, 5'd4, 5'd0, 0, 1, 1);
    tick();
    check("wb0_regwrite", IE_RegWrite, 32'd1);
    check("wb0_wbaddr", IE_WBAddr, 32'd0);
    set_id(1, 5'd0, 5'd0, 5'd9, 1, 0, 1);
    #1 check("wb0_stall", Stall_IFID, 32'd0);
    tick();
    check("wb0_valid", IE_Valid, 32'd1);

    // Invalid decode slot with all controls asserted.
    set_id(0, 5'd1, 5'd2, 5'd3, 1, 1, 1);
    ID_MemWrite = 1'b1;
    tick();
    check("invalid_regwrite", IE_RegWrite, 32'd0);
    check("invalid_memwrite", IE_MemWrite, 32'd0);

    // Reset during a hold discards the held slot.
    set_id(1, 5'd7, 5'd7, 5'd7, 1, 1, 1);
    tick();
    Hold = 1'b1; rst = 1'b1;
    tick();
    check("rst_hold_valid", IE_Valid, 32'd0);
    check("rst_hold_rs", IE_Rs, 32'd0);
    Hold = 1'b0; rst = 1'b0;

`ifdef IDEX_PERF_CNT_EN
    // Bubble counter wraps from all-ones; reset clears both counters.
    set_id(1, 5'd1, 5'd2, 5'd8, 0, 1, 1);
    tick();
    set_id(1, 5'd8, 5'd3, 5'd9, 0, 0, 1);
    force dut.Cnt_Bubble = 32'hFFFF_FFFF;
    m_cb = 32'hFFFF_FFFF;
    #1 release dut.Cnt_Bubble;
    tick();
    check("cnt_bubble_wrap", Cnt_Bubble, 32'd0);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check("cnt_flush_one", Cnt_Flush, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("cnt_rst_bubble", Cnt_Bubble, 32'd0);
    check("cnt_rst_flush", Cnt_Flush, 32'd0);
`endif

    // Random run with a small register space so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 99) < 2);
      Flush = ($urandom_range(0, 99) < 8);
      Hold  = ($urandom_range(0, 99) < 15);
      set_id($urandom_range(0, 99) < 85, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 99) < 40, 1'($urandom));
      ID_MemWrite = 1'($urandom);
      tick();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
